seq_111010_tx: RTL and testbench

- Serial frame transmitter, the transmit end of the 111010 sync-word link.
- Per request it emits the sync word 111010, then a PAYLOAD_W-bit parallel word serialised MSB first, then an idle gap.
- Drives the bit stream consumed by the downstream Mealy overlapping 111010 detector, and serves as its stimulus source in loopback.

---
 rtl/seq_111010_pkg.sv | 27 ++
 rtl/seq_piso_shift.sv | 45 ++++
 rtl/seq_111010_tx.sv | 215 +++++++++++++++++++++
 tb/tb_seq_111010_tx.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_111010_pkg.sv
// -----------------------------------------------------------------------------
// seq_111010_pkg
// Shared definitions for the 111010 sync-word link transmitter: the sync word
// itself, its length, the transmitter state type and a helper that picks one
// sync bit by its transmit position (position 0 goes out first).
// -----------------------------------------------------------------------------
package seq_111010_pkg;

   localparam logic [5:0] SYNC_PATTERN = 6'b111010;
   localparam int         SYNC_LEN     = 6;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SYNC    = 3'd1,
      PAYLOAD = 3'd2,
      PARITY  = 3'd3,
      GAP     = 3'd4
   } tx_state_t;

   // Sync word goes out MSB first, so transmit position idx maps to bit 5-idx.
   function automatic logic sync_bit(input logic [2:0] idx);
      logic [2:0] pos;
      pos = 3'(SYNC_LEN - 1) - idx;
      return SYNC_PATTERN[pos];
   endfunction

endpackage

// File: rtl/seq_piso_shift.sv
// -----------------------------------------------------------------------------
// seq_piso_shift
// Parallel-load, MSB-first shift register used to serialise the frame payload.
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous reset, active low (clears the register)
//   load  - capture d (has priority over shift)
//   shift - shift left by one, zero fill
//   d     - parallel payload
//   msb   - current MSB, i.e. the next payload bit to transmit
// -----------------------------------------------------------------------------
module seq_piso_shift #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         shift,
   input  logic [W-1:0] d,
   output logic         msb
);

   logic [W-1:0] sh_q;
   logic [W-1:0] sh_d;

   always_comb begin
      sh_d = sh_q;
      if (load) begin
         sh_d = d;
      end else if (shift) begin
         sh_d = sh_q << 1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         sh_q <= '0;
      end else begin
         sh_q <= sh_d;
      end
   end

   assign msb = sh_q[W-1];

endmodule

// File: rtl/seq_111010_tx.sv
// -----------------------------------------------------------------------------
// seq_111010_tx
// Serial frame transmitter for the 111010 sync-word link. Each accepted start
// sends the sync word 111010, then PAYLOAD_W payload bits MSB first, then
// holds the line idle for GAP_CYCLES cycles before the next start is taken.
//
// Optional build macro SEQ_111010_TX_PARITY_EN: appends one even-parity bit
// (XOR of the captured payload) after the payload; done moves onto it.
//
// Ports:
//   clk       - clock, rising edge
//   rst       - synchronous reset, active low; aborts a frame without done
//   start     - frame request, only looked at while ready=1
//   data_in   - payload, captured on the edge that accepts start
//   ready     - high only in IDLE
//   busy      - complement of ready
//   out_seq   - serial bit (registered)
//   out_valid - out_seq carries a frame bit (registered)
//   done      - one-cycle pulse with the final frame bit (registered)
//
// state   | meaning
// --------+----------------------------------------------------------------
// IDLE    | waiting for start; accepting edge already drives sync bit 0
// SYNC    | sending sync bits 1..5 (bit_cnt = index of next bit)
// PAYLOAD | shifting the payload out MSB first
// PARITY  | sending the parity bit (parity build only)
// GAP     | line idle; covers the final-bit cycle plus GAP_CYCLES idle cycles
// -----------------------------------------------------------------------------
module seq_111010_tx
   import seq_111010_pkg::*;
#(
   parameter int PAYLOAD_W  = 8,
   parameter int GAP_CYCLES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [PAYLOAD_W-1:0] data_in,
   output logic                 ready,
   output logic                 busy,
   output logic                 out_seq,
   output logic                 out_valid,
   output logic                 done
);

   localparam int CNT_W = $clog2(PAYLOAD_W + 8);
   localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

   localparam logic [CNT_W-1:0] SYNC_LAST_IDX = CNT_W'(SYNC_LEN - 1);
   localparam logic [CNT_W-1:0] PAY_LAST_IDX  = CNT_W'(SYNC_LEN + PAYLOAD_W - 1);
   // Outputs are registered, so the state already reads GAP while the final
   // bit is on the line; the down-counter therefore starts at GAP_CYCLES.
   localparam logic [GAP_W-1:0] GAP_LOAD      = GAP_W'(GAP_CYCLES);

   tx_state_t        state_q, state_d;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
   logic             out_seq_q, out_seq_d;
   logic             out_valid_q, out_valid_d;
   logic             done_q, done_d;
   logic             ready_q, ready_d;
   logic             busy_q, busy_d;

   logic piso_load;
   logic piso_shift;
   logic piso_msb;
   logic last_payload;

   assign last_payload = (bit_cnt_q == PAY_LAST_IDX);

   seq_piso_shift #(
      .W (PAYLOAD_W)
   ) u_piso (
      .clk   (clk),
      .rst   (rst),
      .load  (piso_load),
      .shift (piso_shift),
      .d     (data_in),
      .msb   (piso_msb)
   );

`ifdef SEQ_111010_TX_PARITY_EN
   logic parity_q, parity_d;

   assign parity_d = piso_load ? (^data_in) : parity_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         parity_q <= 1'b0;
      end else begin
         parity_q <= parity_d;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         gap_cnt_q   <= '0;
         out_seq_q   <= 1'b0;
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
         ready_q     <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         out_seq_q   <= out_seq_d;
         out_valid_q <= out_valid_d;
         done_q      <= done_d;
         ready_q     <= ready_d;
         busy_q      <= busy_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      gap_cnt_d  = gap_cnt_q;
      piso_load  = 1'b0;
      piso_shift = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = SYNC;
               bit_cnt_d = CNT_W'(1);
               piso_load = 1'b1;
            end
         end
         SYNC: begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == SYNC_LAST_IDX) begin
               state_d = PAYLOAD;
            end
         end
         PAYLOAD: begin
            piso_shift = 1'b1;
            bit_cnt_d  = bit_cnt_q + 1'b1;
            if (last_payload) begin
`ifdef SEQ_111010_TX_PARITY_EN
               state_d   = PARITY;
`else
               state_d   = GAP;
               bit_cnt_d = '0;
               gap_cnt_d = GAP_LOAD;
`endif
            end
         end
`ifdef SEQ_111010_TX_PARITY_EN
         PARITY: begin
            state_d   = GAP;
            bit_cnt_d = '0;
            gap_cnt_d = GAP_LOAD;
         end
`endif
         GAP: begin
            if (gap_cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Each output flop gets the bit being emitted on this edge, so the first
   // sync bit is visible the cycle after start is sampled.
   always_comb begin
      out_seq_d   = 1'b0;
      out_valid_d = 1'b0;
      done_d      = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               out_valid_d = 1'b1;
               out_seq_d   = SYNC_PATTERN[SYNC_LEN-1];
            end
         end
         SYNC: begin
            out_valid_d = 1'b1;
            out_seq_d   = sync_bit(bit_cnt_q[2:0]);
         end
         PAYLOAD: begin
            out_valid_d = 1'b1;
            out_seq_d   = piso_msb;
`ifndef SEQ_111010_TX_PARITY_EN
            done_d      = last_payload;
`endif
         end
`ifdef SEQ_111010_TX_PARITY_EN
         PARITY: begin
            out_valid_d = 1'b1;
            out_seq_d   = parity_q;
            done_d      = 1'b1;
         end
`endif
         default: begin
         end
      endcase
      ready_d = (state_d == IDLE);
      busy_d  = ~ready_d;
   end

   assign out_seq   = out_seq_q;
   assign out_valid = out_valid_q;
   assign done      = done_q;
   assign ready     = ready_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_seq_111010_tx.sv
// -----------------------------------------------------------------------------
// tb_seq_111010_tx
// Two transmitters (GAP_CYCLES=2 and GAP_CYCLES=0) share one stimulus
// schedule. A timeline model built from the frame rules predicts every output
// on every cycle; table vectors and hand sequences add frame-level checks.
// Trace word layout: {out_valid, out_seq, done, ready, busy}.
// -----------------------------------------------------------------------------
module tb_seq_111010_tx;

   localparam int W     = 8;
   localparam int GAP_A = 2;
   localparam int GAP_B = 0;
   localparam int MAXC  = 400;
`ifdef SEQ_111010_TX_PARITY_EN
   localparam int PAR_EN = 1;
`else
   localparam int PAR_EN = 0;
`endif
   localparam int FLEN = 6 + W + PAR_EN;
   localparam logic [4:0] IDLE_OUT = 5'b00010;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic         start;
   logic [W-1:0] data_in;
   logic ready_a, busy_a, seq_a, valid_a, done_a;
   logic ready_b, busy_b, seq_b, valid_b, done_b;

   seq_111010_tx #(.PAYLOAD_W(W), .GAP_CYCLES(GAP_A)) dut_a (
      .clk(clk), .rst(rst), .start(start), .data_in(data_in),
      .ready(ready_a), .busy(busy_a), .out_seq(seq_a), .out_valid(valid_a), .done(done_a)
   );

   seq_111010_tx #(.PAYLOAD_W(W), .GAP_CYCLES(GAP_B)) dut_b (
      .clk(clk), .rst(rst), .start(start), .data_in(data_in),
      .ready(ready_b), .busy(busy_b), .out_seq(seq_b), .out_valid(valid_b), .done(done_b)
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic         sched_rst   [MAXC];
   logic         sched_start [MAXC];
   logic [W-1:0] sched_data  [MAXC];
   logic [4:0]   tr [2][MAXC];
   logic [4:0]   ex [2][MAXC];

   typedef struct packed {
      logic [7:0]  d;
      logic [13:0] bits14;
      logic        par;
      logic [15:0] hits;
   } vec_t;

   vec_t tbl [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Frame content from the link rules: sync word, payload MSB first, parity.
   function automatic logic [15:0] frame_bits(input logic [W-1:0] d);
      logic [15:0] f;
      logic [5:0]  p;
      p = 6'b111010;
      f = '0;
      for (int i = 5; i >= 0; i--) f = {f[14:0], p[i]};
      for (int i = W - 1; i >= 0; i--) f = {f[14:0], d[i]};
      if (PAR_EN == 1) f = {f[14:0], ^d};
      return f;
   endfunction

   task automatic clear_sched(input int n);
      for (int k = 0; k < n; k++) begin
         sched_rst[k]   = 1'b1;
         sched_start[k] = 1'b0;
         sched_data[k]  = '0;
      end
      sched_rst[0] = 1'b0;
   endtask

   task automatic run_sched(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         tr[0][k] = {valid_a, seq_a, done_a, ready_a, busy_a};
         tr[1][k] = {valid_b, seq_b, done_b, ready_b, busy_b};
         rst      = sched_rst[k];
         start    = sched_start[k];
         data_in  = sched_data[k];
      end
   endtask

   // Timeline model: a start seen at cycle k while free puts FLEN bits on
   // cycles k+1..k+FLEN, keeps busy for g more cycles, then frees the link.
   task automatic build_model(input int d, input int g, input int n);
      int          free_at;
      logic [15:0] f;
      for (int k = 0; k < n; k++) ex[d][k] = IDLE_OUT;
      free_at = 0;
      for (int k = 0; k < n - 1; k++) begin
         if (!sched_rst[k]) begin
            for (int j = k + 1; j < n; j++) ex[d][j] = IDLE_OUT;
            free_at = k + 1;
         end else if (sched_start[k] && k >= free_at) begin
            f = frame_bits(sched_data[k]);
            for (int i = 0; i < FLEN + g; i++) begin
               if (k + 1 + i < n) begin
                  if (i < FLEN) ex[d][k+1+i] = {1'b1, f[FLEN-1-i], (i == FLEN - 1), 1'b0, 1'b1};
                  else          ex[d][k+1+i] = 5'b00001;
               end
            end
            free_at = k + 1 + FLEN + g;
         end
      end
   endtask

   task automatic compare(input string tag, input int n);
      build_model(0, GAP_A, n);
      build_model(1, GAP_B, n);
      for (int k = 1; k < n; k++) begin
         check($sformatf("%s_a_cyc%0d", tag, k), 32'(tr[0][k]), 32'(ex[0][k]));
         check($sformatf("%s_b_cyc%0d", tag, k), 32'(tr[1][k]), 32'(ex[1][k]));
      end
   endtask

   // First contiguous run of valid bits at or after 'from', with a
   // behavioural overlapping 111010 detector applied to it.
   task automatic extract(input int d, input int from, input int n,
                          output int first, output int last, output int cnt,
                          output logic [15:0] bits, output int done_at,
                          output int done_cnt, output logic [15:0] hits);
      logic [5:0] hist;
      logic [5:0] pat;
      pat = 6'b111010;
      first = -1; last = -1; cnt = 0; bits = '0; done_at = -1; done_cnt = 0;
      hits = '0; hist = '0;
      for (int k = from; k < n && first < 0; k++) if (tr[d][k][4] === 1'b1) first = k;
      if (first >= 0) begin
         for (int k = first; k < n && tr[d][k][4] === 1'b1; k++) begin
            last = k;
            bits = {bits[14:0], tr[d][k][3]};
            hist = {hist[4:0], tr[d][k][3]};
            if (cnt >= 5 && cnt < 16 && hist == pat) hits[cnt] = 1'b1;
            if (tr[d][k][2] === 1'b1) begin
               done_cnt++;
               done_at = k;
            end
            cnt++;
         end
      end
   endtask

   initial begin
      int          f1, l1, c1, da1, dc1, f2, l2, c2, da2, dc2;
      logic [15:0] b1, h1, b2, h2, exp_bits;
      int          dones;

      rst = 1'b0; start = 1'b0; data_in = '0;

      tbl[0] = '{d: 8'hA5, bits14: 14'b11101010100101, par: 1'b0, hits: 16'h0020};
      tbl[1] = '{d: 8'h00, bits14: 14'b11101000000000, par: 1'b0, hits: 16'h0020};
      tbl[2] = '{d: 8'hE8, bits14: 14'b11101011101000, par: 1'b0, hits: 16'h0820};
      tbl[3] = '{d: 8'hA4, bits14: 14'b11101010100100, par: 1'b1, hits: 16'h0020};
      tbl[4] = '{d: 8'hFF, bits14: 14'b11101011111111, par: 1'b0, hits: 16'h0020};
      tbl[5] = '{d: 8'h01, bits14: 14'b11101000000001, par: 1'b1, hits: 16'h0020};

      // Single frames from the vector table
      for (int t = 0; t < 6; t++) begin
         clear_sched(30);
         sched_start[2] = 1'b1;
         sched_data[2]  = tbl[t].d;
         sched_data[3]  = ~tbl[t].d;
         run_sched(30);
         compare($sformatf("tbl%0d", t), 30);
         check($sformatf("tbl%0d_reset_state", t), 32'(tr[0][1]), 32'(IDLE_OUT));
         exp_bits = (PAR_EN == 1) ? {1'b0, tbl[t].bits14, tbl[t].par} : {2'b00, tbl[t].bits14};
         extract(0, 0, 30, f1, l1, c1, b1, da1, dc1, h1);
         check($sformatf("tbl%0d_first_bit_cycle", t), 32'(f1), 32'd3);
         check($sformatf("tbl%0d_valid_len", t), 32'(c1), 32'(FLEN));
         check($sformatf("tbl%0d_bits", t), 32'(b1), 32'(exp_bits));
         check($sformatf("tbl%0d_done_on_last", t), 32'(da1), 32'(l1));
         check($sformatf("tbl%0d_done_count", t), 32'(dc1), 32'd1);
         check($sformatf("tbl%0d_detector_hits", t), 32'(h1), 32'(tbl[t].hits));
         check($sformatf("tbl%0d_ready_low_end_gap", t), 32'(tr[0][l1+GAP_A][1]), 32'd0);
         check($sformatf("tbl%0d_ready_back", t), 32'(tr[0][l1+GAP_A+1][1]), 32'd1);
         check($sformatf("tbl%0d_gap0_ready_back", t), 32'(tr[1][l1+1][1]), 32'd1);
      end

      // start held high, data_in changing every cycle
      clear_sched(60);
      for (int k = 2; k < 60; k++) begin
         sched_start[k] = 1'b1;
         sched_data[k]  = W'($urandom);
      end
      run_sched(60);
      compare("hold", 60);
      extract(0, 0, 60, f1, l1, c1, b1, da1, dc1, h1);
      extract(0, l1 + 1, 60, f2, l2, c2, b2, da2, dc2, h2);
      check("hold_a_payload1", 32'((b1 >> PAR_EN) & 16'h00FF), 32'(sched_data[2]));
      check("hold_a_idle_between", 32'(f2 - l1 - 1), 32'(GAP_A + 1));
      check("hold_a_payload2", 32'((b2 >> PAR_EN) & 16'h00FF), 32'(sched_data[f2-1]));
      extract(1, 0, 60, f1, l1, c1, b1, da1, dc1, h1);
      extract(1, l1 + 1, 60, f2, l2, c2, b2, da2, dc2, h2);
      check("hold_b_idle_between", 32'(f2 - l1 - 1), 32'd1);
      check("hold_b_start_after_done", 32'(f2 - 1), 32'(da1 + 1));
      check("hold_b_len2", 32'(c2), 32'(FLEN));

      // Reset while the 4th sync bit is on the line, then a clean frame
      clear_sched(50);
      sched_start[2] = 1'b1;
      sched_data[2]  = 8'h3C;
      sched_rst[6]   = 1'b0;
      sched_start[8] = 1'b1;
      sched_data[8]  = 8'h5A;
      run_sched(50);
      compare("rst", 50);
      check("rst_4th_sync_bit", 32'(tr[0][6][4:3]), 32'b10);
      check("rst_after_abort", 32'(tr[0][7]), 32'(IDLE_OUT));
      dones = 0;
      for (int k = 3; k <= 7; k++) if (tr[0][k][2] !== 1'b0) dones++;
      check("rst_no_done", 32'(dones), 32'd0);
      extract(0, 8, 50, f1, l1, c1, b1, da1, dc1, h1);
      check("rst_new_first", 32'(f1), 32'd9);
      check("rst_new_len", 32'(c1), 32'(FLEN));
      check("rst_new_bits", 32'(b1), 32'(frame_bits(8'h5A)));
      check("rst_new_done", 32'(da1), 32'(l1));

      // Random starts, data and occasional resets against the model
      clear_sched(MAXC);
      for (int k = 2; k < MAXC; k++) begin
         sched_start[k] = ($urandom_range(0, 3) == 0);
         sched_data[k]  = W'($urandom);
         if ($urandom_range(0, 59) == 0) sched_rst[k] = 1'b0;
      end
      run_sched(MAXC);
      compare("rand", MAXC);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
